dmem_arbiter: RTL and testbench

Arbitrates the single-port synchronous data memory between the core's load/store path and an external master port (program loader / debug). Issues one access per cycle with byte write strobes, tracks which requester owns each outstanding access, and returns read data or write acknowledge one cycle later. Sits between the MEM stage's store/load control and the data-memory macro.

---
 rtl/dmem_arbiter_pkg.sv | 24 ++
 rtl/dmem_arbiter.sv | 140 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_arbiter_pkg.sv
// Shared types for the data-memory arbiter: owner encoding and request/response bundles.
package dmem_arbiter_pkg;

    localparam int DMEM_ADDR_W = 32;
    localparam int DMEM_DATA_W = 32;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_LSU,
        OWN_EXT
    } dmem_owner_e;

    typedef struct packed {
        logic [DMEM_DATA_W/8-1:0] we;
        logic [DMEM_ADDR_W-1:0]   addr;
        logic [DMEM_DATA_W-1:0]   wdata;
    } dmem_req_t;

    typedef struct packed {
        logic                   rvalid;
        logic [DMEM_DATA_W-1:0] rdata;
    } dmem_rsp_t;

endpackage

// File: rtl/dmem_arbiter.sv
// Single-port data-memory arbiter between the LSU and an external master.
// Define DMEM_ARB_RR_EN for round-robin on conflict; default is LSU priority with EXT starvation override.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                lsu_req_i,
    input  logic [DATA_W/8-1:0] lsu_we_i,
    input  logic [ADDR_W-1:0]   lsu_addr_i,
    input  logic [DATA_W-1:0]   lsu_wdata_i,
    output logic                lsu_gnt_o,
    output logic                lsu_rvalid_o,
    output logic [DATA_W-1:0]   lsu_rdata_o,
    input  logic                ext_req_i,
    input  logic [DATA_W/8-1:0] ext_we_i,
    input  logic [ADDR_W-1:0]   ext_addr_i,
    input  logic [DATA_W-1:0]   ext_wdata_i,
    output logic                ext_gnt_o,
    output logic                ext_rvalid_o,
    output logic [DATA_W-1:0]   ext_rdata_o,
    output logic                mem_req_o,
    output logic [DATA_W/8-1:0] mem_we_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    output logic [DATA_W-1:0]   mem_wdata_o,
    input  logic [DATA_W-1:0]   mem_rdata_i
);

    dmem_owner_e owner_q, owner_d;
    logic        load_q, load_d;
    logic        ext_wins;
    logic        conflict;

    assign conflict = lsu_req_i && ext_req_i;

`ifdef DMEM_ARB_RR_EN
    // rr_q set means EXT takes the next conflicting cycle
    logic rr_q, rr_d;

    assign ext_wins = rr_q;

    always_comb begin
        rr_d = rr_q;
        if (conflict) begin
            rr_d = !rr_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rr_q <= 1'b0;
        end else begin
            rr_q <= rr_d;
        end
    end
`else
    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    logic [7:0] starve_cnt_q, starve_cnt_d;

    assign ext_wins = (starve_cnt_q == STARVE_LIM);

    always_comb begin
        starve_cnt_d = '0;
        if (ext_req_i && !ext_gnt_o) begin
            starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q : starve_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt_q <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
        end
    end
`endif

    // Grants are gated by reset so every output reads zero while rst_ni is low.
    always_comb begin
        lsu_gnt_o = 1'b0;
        ext_gnt_o = 1'b0;
        if (rst_ni) begin
            if (conflict) begin
                ext_gnt_o = ext_wins;
                lsu_gnt_o = !ext_wins;
            end else begin
                lsu_gnt_o = lsu_req_i;
                ext_gnt_o = ext_req_i;
            end
        end
    end

    always_comb begin
        mem_we_o    = '0;
        mem_addr_o  = '0;
        mem_wdata_o = '0;
        if (ext_gnt_o) begin
            mem_we_o    = ext_we_i;
            mem_addr_o  = ext_addr_i;
            mem_wdata_o = ext_wdata_i;
        end else if (lsu_gnt_o) begin
            mem_we_o    = lsu_we_i;
            mem_addr_o  = lsu_addr_i;
            mem_wdata_o = lsu_wdata_i;
        end
    end

    assign mem_req_o = lsu_gnt_o | ext_gnt_o;

    always_comb begin
        owner_d = OWN_NONE;
        if (ext_gnt_o) begin
            owner_d = OWN_EXT;
        end else if (lsu_gnt_o) begin
            owner_d = OWN_LSU;
        end
        load_d = (mem_we_o == '0);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            owner_q <= OWN_NONE;
            load_q  <= 1'b0;
        end else begin
            owner_q <= owner_d;
            load_q  <= load_d;
        end
    end

    assign lsu_rvalid_o = (owner_q == OWN_LSU);
    assign ext_rvalid_o = (owner_q == OWN_EXT);
    assign lsu_rdata_o  = (lsu_rvalid_o && load_q) ? mem_rdata_i : '0;
    assign ext_rdata_o  = (ext_rvalid_o && load_q) ? mem_rdata_i : '0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Randomized, model-checked bench for dmem_arbiter, with directed cases for load, store,
// contention, reset during an access and back-to-back loads.
module tb_dmem_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int BW   = DW / 8;
    localparam int SMAX = 8;

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          lsu_req_i = 1'b0;
    logic [BW-1:0] lsu_we_i = '0;
    logic [AW-1:0] lsu_addr_i = '0;
    logic [DW-1:0] lsu_wdata_i = '0;
    logic          lsu_gnt_o, lsu_rvalid_o;
    logic [DW-1:0] lsu_rdata_o;
    logic          ext_req_i = 1'b0;
    logic [BW-1:0] ext_we_i = '0;
    logic [AW-1:0] ext_addr_i = '0;
    logic [DW-1:0] ext_wdata_i = '0;
    logic          ext_gnt_o, ext_rvalid_o;
    logic [DW-1:0] ext_rdata_o;
    logic          mem_req_o;
    logic [BW-1:0] mem_we_o;
    logic [AW-1:0] mem_addr_o;
    logic [DW-1:0] mem_wdata_o;
    logic [DW-1:0] mem_rdata_i;

    int checks = 0;
    int errors = 0;

    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_addr_i(lsu_addr_i),
        .lsu_wdata_i(lsu_wdata_i), .lsu_gnt_o(lsu_gnt_o), .lsu_rvalid_o(lsu_rvalid_o),
        .lsu_rdata_o(lsu_rdata_o),
        .ext_req_i(ext_req_i), .ext_we_i(ext_we_i), .ext_addr_i(ext_addr_i),
        .ext_wdata_i(ext_wdata_i), .ext_gnt_o(ext_gnt_o), .ext_rvalid_o(ext_rvalid_o),
        .ext_rdata_o(ext_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    function automatic logic [31:0] init_word(input int i);
        if (i == 4) return 32'hDEADBEEF;
        return (32'h0101_0101 * 32'(i)) ^ 32'hA5A5_5A5A;
    endfunction

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic rand_fields(output logic [BW-1:0] we, output logic [AW-1:0] a,
                               output logic [DW-1:0] d);
        we = ($urandom_range(0, 1) == 1) ? 4'($urandom_range(1, 15)) : 4'd0;
        a  = 32'($urandom_range(0, 63));
        d  = $urandom;
    endtask

    // Synchronous memory: a request seen mid-cycle is served at the next rising edge.
    initial begin : mem_emul
        logic [DW-1:0] arr [16];
        logic          cr;
        logic [BW-1:0] cw;
        logic [AW-1:0] ca;
        logic [DW-1:0] cd;
        for (int i = 0; i < 16; i++) arr[i] = init_word(i);
        mem_rdata_i = '0;
        forever begin
            @(negedge clk_i);
            cr = mem_req_o; cw = mem_we_o; ca = mem_addr_o; cd = mem_wdata_o;
            @(posedge clk_i);
            if (cr && cw == '0) mem_rdata_i = arr[ca[5:2]];
            else mem_rdata_i = $urandom;
            if (cr) begin
                for (int b = 0; b < BW; b++)
                    if (cw[b]) arr[ca[5:2]][8*b +: 8] = cd[8*b +: 8];
            end
        end
    end

    // Reference model: who should win, what memory should hold, what each response carries.
    initial begin : model
        logic [DW-1:0] ref_mem [16];
        int            m_starved;
        bit            m_rr_ext;
        bit            p_vld, p_ext;
        logic [DW-1:0] p_data;
        bit            el, ee, ext_first;
        logic [BW-1:0] we;
        logic [AW-1:0] ad;
        logic [DW-1:0] wd;
        for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
        m_starved = 0; m_rr_ext = 0; p_vld = 0; p_ext = 0; p_data = '0;
        forever begin
            @(negedge clk_i);
            if (!rst_ni) begin
                chk("rst_lsu_gnt", 64'(lsu_gnt_o), 64'd0);
                chk("rst_ext_gnt", 64'(ext_gnt_o), 64'd0);
                chk("rst_lsu_rvalid", 64'(lsu_rvalid_o), 64'd0);
                chk("rst_ext_rvalid", 64'(ext_rvalid_o), 64'd0);
                chk("rst_lsu_rdata", 64'(lsu_rdata_o), 64'd0);
                chk("rst_ext_rdata", 64'(ext_rdata_o), 64'd0);
                chk("rst_mem_req", 64'(mem_req_o), 64'd0);
                chk("rst_mem_we", 64'(mem_we_o), 64'd0);
                chk("rst_mem_addr", 64'(mem_addr_o), 64'd0);
                chk("rst_mem_wdata", 64'(mem_wdata_o), 64'd0);
                m_starved = 0; m_rr_ext = 0; p_vld = 0;
            end else begin
`ifdef DMEM_ARB_RR_EN
                ext_first = m_rr_ext;
`else
                ext_first = (m_starved >= SMAX);
`endif
                ee = ext_req_i && (!lsu_req_i || ext_first);
                el = lsu_req_i && !ee;
                we = ee ? ext_we_i : (el ? lsu_we_i : '0);
                ad = ee ? ext_addr_i : lsu_addr_i;
                wd = ee ? ext_wdata_i : lsu_wdata_i;
                chk("lsu_gnt", 64'(lsu_gnt_o), 64'(el));
                chk("ext_gnt", 64'(ext_gnt_o), 64'(ee));
                chk("mem_req", 64'(mem_req_o), 64'(el || ee));
                chk("mem_we", 64'(mem_we_o), 64'(we));
                if (el || ee) begin
                    chk("mem_addr", 64'(mem_addr_o), 64'(ad));
                    chk("mem_wdata", 64'(mem_wdata_o), 64'(wd));
                end
                chk("lsu_rvalid", 64'(lsu_rvalid_o), 64'(p_vld && !p_ext));
                chk("ext_rvalid", 64'(ext_rvalid_o), 64'(p_vld && p_ext));
                chk("lsu_rdata", 64'(lsu_rdata_o), (p_vld && !p_ext) ? 64'(p_data) : 64'd0);
                chk("ext_rdata", 64'(ext_rdata_o), (p_vld && p_ext) ? 64'(p_data) : 64'd0);
                p_vld  = el || ee;
                p_ext  = ee;
                p_data = (we == '0) ? ref_mem[ad[5:2]] : '0;
                if (el || ee) begin
                    for (int b = 0; b < BW; b++)
                        if (we[b]) ref_mem[ad[5:2]][8*b +: 8] = wd[8*b +: 8];
                end
                if (ext_req_i && !ee) m_starved = (m_starved < SMAX) ? m_starved + 1 : SMAX;
                else m_starved = 0;
                if (lsu_req_i && ext_req_i) m_rr_ext = !m_rr_ext;
            end
        end
    end

    initial begin : driver
        int  first_ext, lsu_run;
        bit  lg, eg;
        lsu_req_i = 1'b1;
        ext_req_i = 1'b1;
        @(negedge clk_i);
        chk("rst_req_blocked", 64'(mem_req_o), 64'd0);
        step();
        lsu_req_i = 1'b0;
        ext_req_i = 1'b0;
        step();
        rst_ni = 1'b1;

        // LSU load of the preloaded word
        step();
        lsu_req_i = 1'b1; lsu_we_i = 4'b0000; lsu_addr_i = 32'h10;
        @(negedge clk_i);
        chk("load_gnt", 64'(lsu_gnt_o), 64'd1);
        chk("load_ext_idle", 64'(ext_gnt_o), 64'd0);
        step();
        lsu_req_i = 1'b0;
        @(negedge clk_i);
        chk("load_rvalid", 64'(lsu_rvalid_o), 64'd1);
        chk("load_rdata", 64'(lsu_rdata_o), 64'hDEADBEEF);
        chk("load_ext_rvalid", 64'(ext_rvalid_o), 64'd0);

        // LSU byte store
        step();
        lsu_req_i = 1'b1; lsu_we_i = 4'b0100; lsu_addr_i = 32'h22; lsu_wdata_i = 32'h00AB0000;
        @(negedge clk_i);
        chk("store_we", 64'(mem_we_o), 64'h4);
        chk("store_addr", 64'(mem_addr_o), 64'h22);
        step();
        lsu_req_i = 1'b0; lsu_we_i = '0;
        @(negedge clk_i);
        chk("store_rvalid", 64'(lsu_rvalid_o), 64'd1);
        chk("store_rdata", 64'(lsu_rdata_o), 64'd0);

        // Continuous contention
        step();
        lsu_req_i = 1'b1; lsu_addr_i = 32'h30;
        ext_req_i = 1'b1; ext_we_i = '0; ext_addr_i = 32'h34;
        first_ext = 0;
        lsu_run   = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk_i);
`ifdef DMEM_ARB_RR_EN
            chk("rr_lsu", 64'(lsu_gnt_o), 64'(k % 2));
            chk("rr_ext", 64'(ext_gnt_o), 64'(k % 2 == 0));
`else
            if (ext_gnt_o && first_ext == 0) first_ext = k;
            if (lsu_gnt_o && first_ext == 0) lsu_run++;
            if (k == 10) chk("starve_lsu_back", 64'(lsu_gnt_o), 64'd1);
`endif
            step();
        end
`ifndef DMEM_ARB_RR_EN
        chk("starve_lsu_run", 64'(lsu_run), 64'd8);
        chk("starve_ext_cycle", 64'(first_ext), 64'd9);
`endif
        lsu_req_i = 1'b0;
        ext_req_i = 1'b0;

        // Reset lands while an EXT load response is outstanding
        step();
        ext_req_i = 1'b1; ext_we_i = '0; ext_addr_i = 32'h08;
        @(negedge clk_i);
        chk("rstmid_ext_gnt", 64'(ext_gnt_o), 64'd1);
        step();
        ext_req_i = 1'b0;
        rst_ni = 1'b0;
        @(negedge clk_i);
        chk("rstmid_ext_rvalid", 64'(ext_rvalid_o), 64'd0);
        step();
        step();
        rst_ni = 1'b1;
        @(negedge clk_i);
        chk("rstmid_no_stale", 64'(ext_rvalid_o), 64'd0);

        // Four back-to-back LSU loads
        step();
        lsu_req_i = 1'b1; lsu_we_i = '0;
        for (int k = 0; k < 4; k++) begin
            lsu_addr_i = 32'(16 + 4 * k);
            @(negedge clk_i);
            chk("b2b_gnt", 64'(lsu_gnt_o), 64'd1);
            if (k > 0) chk("b2b_rvalid", 64'(lsu_rvalid_o), 64'd1);
            step();
        end
        lsu_req_i = 1'b0;
        @(negedge clk_i);
        chk("b2b_rvalid_last", 64'(lsu_rvalid_o), 64'd1);
        step();
        @(negedge clk_i);
        chk("b2b_idle", 64'(lsu_rvalid_o), 64'd0);

        // Random traffic; a pending request keeps its fields until granted
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk_i);
            #1;
            lg = lsu_gnt_o;
            eg = ext_gnt_o;
            @(posedge clk_i);
            #1;
            if (!lsu_req_i || lg) begin
                lsu_req_i = (n >= 1500) || ($urandom_range(0, 9) < 7);
                rand_fields(lsu_we_i, lsu_addr_i, lsu_wdata_i);
            end
            if (!ext_req_i || eg) begin
                ext_req_i = ($urandom_range(0, 9) < 5);
                rand_fields(ext_we_i, ext_addr_i, ext_wdata_i);
            end
        end
        lsu_req_i = 1'b0;
        ext_req_i = 1'b0;
        step();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
